// File: rtl/cic_pkg.sv
// Shared CIC definitions: parameter range limits, the signed sample type and width helpers.
// The integrator, decimator and comb blocks all import this package.
package cic_pkg;

    localparam int N_MAX    = 8;
    localparam int M_MAX    = 4;
    localparam int CH_MAX   = 16;
    localparam int SAMPLE_W = 10;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A single channel still needs a one-bit index so the port never collapses to zero width.
    function automatic int chanWidth(input int channels);
        return (clog2(channels) > 1) ? clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/cic_comb_mc_if.sv
// Strobed sample stream into and out of the multi-channel comb section.
interface cic_comb_mc_if #(
    parameter int W  = 10,
    parameter int CH = 2
);
    import cic_pkg::*;

    localparam int CW = chanWidth(CH);

    logic                 din_vld;
    logic [CW-1:0]        din_ch;
    logic signed [W-1:0]  din;
    logic                 dout_vld;
    logic [CW-1:0]        dout_ch;
    logic signed [W-1:0]  dout;

    modport master (
        output din_vld, din_ch, din,
        input  dout_vld, dout_ch, dout
    );

    modport slave (
        input  din_vld, din_ch, din,
        output dout_vld, dout_ch, dout
    );

endinterface

// File: rtl/cic_comb_mc_comb_stage.sv
// One differentiator y = x - x[n-M] with an independent M-deep history per channel.
// Histories advance only on accepted samples of their own channel.
module comb_stage
    import cic_pkg::*;
#(
    parameter int W  = 10,
    parameter int M  = 1,
    parameter int CH = 2,
    parameter int CW = chanWidth(CH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          vld_i,
    input  logic [CW-1:0] ch_i,
    input  logic [W-1:0]  data_i,
    output logic          vld_o,
    output logic [CW-1:0] ch_o,
    output logic [W-1:0]  data_o
);

    localparam logic [CW:0] CH_LIMIT = (CW + 1)'(CH);

    logic [W-1:0]  hist_q [CH][M];
    logic          vld_q;
    logic [CW-1:0] ch_q;
    logic [W-1:0]  data_q;

    logic [W-1:0]  tap_d;
    logic [W-1:0]  data_d;
    logic          accept_d;

    // Out-of-range channel tags are dropped here so they never touch any history.
    always_comb begin
        tap_d = '0;
        for (int c = 0; c < CH; c++) begin
            if (ch_i == CW'(c)) begin
                tap_d = hist_q[c][M-1];
            end
        end
        accept_d = vld_i && ({1'b0, ch_i} < CH_LIMIT);
        data_d   = data_i - tap_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            ch_q   <= '0;
            data_q <= '0;
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < M; j++) begin
                    hist_q[c][j] <= '0;
                end
            end
        end else if (clr) begin
            vld_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < M; j++) begin
                    hist_q[c][j] <= '0;
                end
            end
        end else begin
            vld_q <= accept_d;
            if (accept_d) begin
                ch_q   <= ch_i;
                data_q <= data_d;
                // History updates on the same edge the difference is registered, so a
                // same-channel sample in the very next cycle already sees it.
                for (int c = 0; c < CH; c++) begin
                    if (ch_i == CW'(c)) begin
                        hist_q[c][0] <= data_i;
                        for (int j = 1; j < M; j++) begin
                            hist_q[c][j] <= hist_q[c][j-1];
                        end
                    end
                end
            end
        end
    end

    assign vld_o  = vld_q;
    assign ch_o   = ch_q;
    assign data_o = data_q;

endmodule

// File: rtl/cic_comb_mc.sv
// Multi-channel CIC comb section: N cascaded comb_stage instances, one register level each,
// so a sample presented on din emerges on dout N cycles later.
module cic_comb_mc
    import cic_pkg::*;
#(
    parameter int W  = 10,
    parameter int N  = 3,
    parameter int M  = 1,
    parameter int CH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    cic_comb_mc_if.slave  bus
);

    localparam int CW = chanWidth(CH);

    logic          vld  [N+1];
    logic [CW-1:0] ch   [N+1];
    logic [W-1:0]  data [N+1];

    assign vld[0]  = bus.din_vld;
    assign ch[0]   = bus.din_ch;
    assign data[0] = bus.din;

    for (genvar k = 0; k < N; k++) begin : g_stage
        comb_stage #(
            .W  (W),
            .M  (M),
            .CH (CH),
            .CW (CW)
        ) u_stage (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (clr),
            .vld_i  (vld[k]),
            .ch_i   (ch[k]),
            .data_i (data[k]),
            .vld_o  (vld[k+1]),
            .ch_o   (ch[k+1]),
            .data_o (data[k+1])
        );
    end

    assign bus.dout_vld = vld[N];
    assign bus.dout_ch  = ch[N];
    assign bus.dout     = data[N];

endmodule

// File: tb/tb_cic_comb_mc.sv
// Bench for cic_comb_mc: randomized two-channel streams checked against a binomial reference
// model, plus directed impulse/wrap runs on two single-channel configurations.
module tb_cic_comb_mc;
    import cic_pkg::*;

    localparam int W  = 10;
    localparam int N  = 3;
    localparam int M  = 2;
    localparam int CH = 2;
    localparam int CW = chanWidth(CH);

    typedef struct packed {
        int cyc;
        int ch;
        int data;
    } rec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic clr  = 1'b0;
    int   cyc  = 0;
    int   vectors = 0;
    int   miscompares = 0;
    rec_t expQ[$];
    rec_t actQ[$];
    int   hist[CH][$];

    cic_comb_mc_if #(.W(W), .CH(CH)) cif ();
    cic_comb_mc_if #(.W(W), .CH(1))  ifA ();
    cic_comb_mc_if #(.W(W), .CH(1))  ifB ();

    cic_comb_mc #(.W(W), .N(N), .M(M), .CH(CH)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .bus(cif.slave));
    cic_comb_mc #(.W(W), .N(3), .M(1), .CH(1)) dutA (
        .clk(clk), .rstn(rstn), .clr(clr), .bus(ifA.slave));
    cic_comb_mc #(.W(W), .N(1), .M(1), .CH(1)) dutB (
        .clk(clk), .rstn(rstn), .clr(clr), .bus(ifB.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A sample driven in cycle c is expected on dout in cycle c+N.
    always @(negedge clk) begin
        if (cif.dout_vld === 1'b1) begin
            actQ.push_back('{cyc, int'(cif.dout_ch), int'(cif.dout)});
        end
    end

    function automatic int wrapW(input int value);
        logic signed [W-1:0] t;
        t = value[W-1:0];
        return int'(t);
    endfunction

    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 1; i <= k; i++) begin
            r = r * (n - k + i) / i;
        end
        return r;
    endfunction

    // y[n] = sum_i (-1)^i C(N,i) x[n-i*M] over this channel's samples since the last flush.
    function automatic int modelSample(input int ch, input int x);
        int acc;
        acc = 0;
        hist[ch].push_front(x);
        if (hist[ch].size() > N * M + 1) begin
            void'(hist[ch].pop_back());
        end
        for (int i = 0; i <= N; i++) begin
            if (i * M < hist[ch].size()) begin
                acc += ((i % 2) ? -binom(N, i) : binom(N, i)) * hist[ch][i*M];
            end
        end
        return wrapW(acc);
    endfunction

    function automatic void flushModel(input int lastKept);
        rec_t kept[$];
        foreach (expQ[i]) begin
            if (expQ[i].cyc <= lastKept) begin
                kept.push_back(expQ[i]);
            end
        end
        expQ = kept;
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
        end
    endfunction

    task automatic driveCycle(input bit vld, input int ch, input int data, input bit clrIn);
        rec_t r;
        @(negedge clk);
        cif.din_vld = vld;
        cif.din_ch  = CW'(ch);
        cif.din     = W'(data);
        clr         = clrIn;
        if (clrIn) begin
            flushModel(cyc);
        end else if (vld) begin
            r.cyc  = cyc + N;
            r.ch   = ch;
            r.data = modelSample(ch, data);
            expQ.push_back(r);
        end
    endtask

    task automatic test_reset();
        cif.din_vld = 1'b0;
        cif.din_ch  = '0;
        cif.din     = '0;
        ifA.din_vld = 1'b0;
        ifA.din_ch  = '0;
        ifA.din     = '0;
        ifB.din_vld = 1'b0;
        ifB.din_ch  = '0;
        ifB.din     = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 4;
        if (cif.dout_vld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset dout_vld: got %b, expected 0", cif.dout_vld);
        end
        if (cif.dout !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset dout: got %0d, expected 0", cif.dout);
        end
        if (cif.dout_ch !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset dout_ch: got %0d, expected 0", cif.dout_ch);
        end
        if (ifA.dout_vld !== 1'b0 || ifB.dout_vld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset small vld: got %b/%b, expected 0/0", ifA.dout_vld, ifB.dout_vld);
        end
        rstn = 1'b1;
    endtask

    task automatic test_small_configs();
        int aExp[6] = '{1, -3, 3, -1, 0, 0};
        int bExp[2] = '{511, 1};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors += 2;
            if (k >= 3 && k < 9) begin
                if (ifA.dout_vld !== 1'b1 || int'(ifA.dout) !== aExp[k-3]) begin
                    miscompares++;
                    $display("[TB] FAIL cfgA k=%0d: got vld=%b data=%0d, expected vld=1 data=%0d",
                             k, ifA.dout_vld, ifA.dout, aExp[k-3]);
                end
            end else if (ifA.dout_vld !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL cfgA k=%0d: got vld=%b, expected vld=0", k, ifA.dout_vld);
            end
            if (k >= 1 && k < 3) begin
                if (ifB.dout_vld !== 1'b1 || int'(ifB.dout) !== bExp[k-1]) begin
                    miscompares++;
                    $display("[TB] FAIL cfgB k=%0d: got vld=%b data=%0d, expected vld=1 data=%0d",
                             k, ifB.dout_vld, ifB.dout, bExp[k-1]);
                end
            end else if (ifB.dout_vld !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL cfgB k=%0d: got vld=%b, expected vld=0", k, ifB.dout_vld);
            end
            ifA.din_vld = (k < 6);
            ifA.din     = (k == 0) ? W'(1) : W'(0);
            ifB.din_vld = (k < 2);
            ifB.din     = (k == 0) ? W'(511) : W'(-512);
        end
    endtask

    task automatic test_interleave();
        int ch0Exp[8] = '{1, 0, -3, 0, 3, 0, -1, 0};
        int ch1Exp[8] = '{7, 7, -14, -14, 7, 7, 0, 0};
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 20; i++) begin
            driveCycle(1'b1, i % 2, (i % 2) ? 7 : ((i == 0) ? 1 : 0), 1'b0);
        end
        repeat (N + 2) driveCycle(1'b0, 0, 0, 1'b0);
        foreach (actQ[i]) begin
            if (actQ[i].ch == 0 && n0 < 8) begin
                vectors++;
                if (actQ[i].data !== ch0Exp[n0]) begin
                    miscompares++;
                    $display("[TB] FAIL interleave ch0[%0d]: got %0d, expected %0d", n0, actQ[i].data, ch0Exp[n0]);
                end
                n0++;
            end else if (actQ[i].ch == 1 && n1 < 8) begin
                vectors++;
                if (actQ[i].data !== ch1Exp[n1]) begin
                    miscompares++;
                    $display("[TB] FAIL interleave ch1[%0d]: got %0d, expected %0d", n1, actQ[i].data, ch1Exp[n1]);
                end
                n1++;
            end
        end
        vectors++;
        if (actQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL interleave count: got %0d outputs, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            vectors++;
            if (actQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL interleave out%0d: got cyc=%0d ch=%0d data=%0d, expected cyc=%0d ch=%0d data=%0d",
                         i, actQ[i].cyc, actQ[i].ch, actQ[i].data, expQ[i].cyc, expQ[i].ch, expQ[i].data);
            end
        end
        actQ.delete();
        expQ.delete();
    endtask

    task automatic test_gaps();
        int n0 = 0;
        int chSel;
        driveCycle(1'b0, 0, 0, 1'b1);
        for (int s = 0; s < 22; s++) begin
            chSel = (s >= 4 && s <= 6) ? 0 : s % 2;
            if (!(s >= 5 && s <= 6)) begin
                repeat ($urandom_range(0, 5)) driveCycle(1'b0, 0, 0, 1'b0);
            end
            if (chSel == 0) begin
                driveCycle(1'b1, 0, (n0 == 0) ? 1 : 0, 1'b0);
                n0++;
            end else begin
                driveCycle(1'b1, 1, 7, 1'b0);
            end
        end
        repeat (N + 2) driveCycle(1'b0, 0, 0, 1'b0);
        vectors++;
        if (actQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL gaps count: got %0d outputs, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            vectors++;
            if (actQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL gaps out%0d: got cyc=%0d ch=%0d data=%0d, expected cyc=%0d ch=%0d data=%0d",
                         i, actQ[i].cyc, actQ[i].ch, actQ[i].data, expQ[i].cyc, expQ[i].ch, expQ[i].data);
            end
        end
        actQ.delete();
        expQ.delete();
    endtask

    task automatic test_clr();
        logic signed [W-1:0] held;
        logic [CW-1:0]       heldCh;
        driveCycle(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            driveCycle(1'b1, $urandom_range(0, CH - 1), int'($urandom_range(0, 1023)) - 512, 1'b0);
        end
        driveCycle(1'b1, 1, 100, 1'b1);
        held   = cif.dout;
        heldCh = cif.dout_ch;
        driveCycle(1'b0, 0, 0, 1'b0);
        vectors += 3;
        if (cif.dout_vld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr dout_vld: got %b, expected 0", cif.dout_vld);
        end
        if (cif.dout !== held) begin
            miscompares++;
            $display("[TB] FAIL clr dout hold: got %0d, expected %0d", cif.dout, held);
        end
        if (cif.dout_ch !== heldCh) begin
            miscompares++;
            $display("[TB] FAIL clr dout_ch hold: got %0d, expected %0d", cif.dout_ch, heldCh);
        end
        for (int i = 0; i < 9; i++) begin
            driveCycle(1'b1, 0, (i == 0) ? 1 : 0, 1'b0);
        end
        repeat (N + 2) driveCycle(1'b0, 0, 0, 1'b0);
        vectors++;
        if (actQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL clr count: got %0d outputs, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            vectors++;
            if (actQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL clr out%0d: got cyc=%0d ch=%0d data=%0d, expected cyc=%0d ch=%0d data=%0d",
                         i, actQ[i].cyc, actQ[i].ch, actQ[i].data, expQ[i].cyc, expQ[i].ch, expQ[i].data);
            end
        end
        actQ.delete();
        expQ.delete();
    endtask

    task automatic test_rst();
        for (int i = 0; i < 10; i++) begin
            driveCycle(1'b1, $urandom_range(0, CH - 1), int'($urandom_range(0, 1023)) - 512, 1'b0);
        end
        @(negedge clk);
        cif.din_vld = 1'b0;
        #2;
        rstn = 1'b0;
        flushModel(cyc);
        #1;
        vectors += 3;
        if (cif.dout_vld !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst dout_vld: got %b, expected 0", cif.dout_vld);
        end
        if (cif.dout !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst dout: got %0d, expected 0", cif.dout);
        end
        if (cif.dout_ch !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst dout_ch: got %0d, expected 0", cif.dout_ch);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            driveCycle(1'b1, 1, 7, 1'b0);
        end
        repeat (N + 2) driveCycle(1'b0, 0, 0, 1'b0);
        vectors++;
        if (actQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL rst count: got %0d outputs, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            vectors++;
            if (actQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL rst out%0d: got cyc=%0d ch=%0d data=%0d, expected cyc=%0d ch=%0d data=%0d",
                         i, actQ[i].cyc, actQ[i].ch, actQ[i].data, expQ[i].cyc, expQ[i].ch, expQ[i].data);
            end
        end
        actQ.delete();
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            driveCycle(1'b1, (i < 4) ? 0 : int'($urandom_range(0, CH - 1)),
                       int'($urandom_range(0, 1023)) - 512, 1'b0);
        end
        repeat (N + 2) driveCycle(1'b0, 0, 0, 1'b0);
        vectors += 2;
        if (int'(cif.dout) !== expQ[expQ.size()-1].data) begin
            miscompares++;
            $display("[TB] FAIL b2b dout hold: got %0d, expected %0d", cif.dout, expQ[expQ.size()-1].data);
        end
        if (int'(cif.dout_ch) !== expQ[expQ.size()-1].ch) begin
            miscompares++;
            $display("[TB] FAIL b2b dout_ch hold: got %0d, expected %0d", cif.dout_ch, expQ[expQ.size()-1].ch);
        end
        vectors++;
        if (actQ.size() != expQ.size()) begin
            miscompares++;
            $display("[TB] FAIL b2b count: got %0d outputs, expected %0d", actQ.size(), expQ.size());
        end
        for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
            vectors++;
            if (actQ[i] !== expQ[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b out%0d: got cyc=%0d ch=%0d data=%0d, expected cyc=%0d ch=%0d data=%0d",
                         i, actQ[i].cyc, actQ[i].ch, actQ[i].data, expQ[i].cyc, expQ[i].ch, expQ[i].data);
            end
        end
        actQ.delete();
        expQ.delete();
    endtask

    initial begin
        test_reset();
        test_small_configs();
        test_interleave();
        test_gaps();
        test_clr();
        test_rst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
